// File: rtl/seg_pkg.sv
// Shared types, glyph table and polarity helper for the seven-segment scanner.
package seg_pkg;

    typedef logic [6:0] seg_t;

    // Logical (pre-polarity) value with every segment dark.
    localparam seg_t SEG_OFF = 7'h00;

    // Active-high glyphs {g,f,e,d,c,b,a} for 0-9 and A b C d E F.
    localparam seg_t HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic apply_pol(input logic value, input bit active_low);
        return value ^ active_low;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph, with a blank override.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       segs
);

    always_comb begin
        segs = blank ? SEG_OFF : HEX_GLYPH[nibble];
    end

endmodule

// File: rtl/seg_display_scanner.sv
// N-digit multiplexed seven-segment scanner with guard interval, leading-zero
// blanking and frame-synchronous display updates.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int GUARD      = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clockin,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DIGITS);

    localparam logic [PW-1:0] PCNT_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic          PIN_OFF    = apply_pol(1'b0, ACTIVE_LOW);

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("seg_display_scanner: DIGITS must be in 2..8");
    end
    if (DIV < GUARD + 2) begin : g_bad_div
        $error("seg_display_scanner: CLK_HZ/SCAN_HZ must be at least GUARD+2");
    end

    logic [PW-1:0]         pcnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   pend_digits_reg;
    logic [DIGITS-1:0]     pend_dp_reg;
    logic [4*DIGITS-1:0]   act_digits_reg;
    logic [DIGITS-1:0]     act_dp_reg;
    logic [DIGITS-1:0]     an_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic                  frame_tick_reg;

    logic                  advance;
    logic                  wrap;
    logic [3:0]            act_nib [DIGITS];
    logic [DIGITS-1:0]     blank_vec;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    seg_t                  dec_segs;

    logic [DIGITS-1:0]     an_raw;
    seg_t                  seg_raw;
    logic                  dp_raw;
    logic [DIGITS-1:0]     an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    assign advance = en && (pcnt_reg == PCNT_LAST);
    assign wrap    = advance && (idx_reg == IDX_LAST);

    // A digit is blank only if it and everything to its left is zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign act_nib[gi] = act_digits_reg[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = blank_lz && (act_digits_reg[4*DIGITS-1:4*gi] == '0);
        end
    end

    assign cur_nib   = act_nib[idx_reg];
    assign cur_blank = blank_vec[idx_reg];

    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .segs   (dec_segs)
    );

    always_comb begin
        an_raw = '0;
        if (en && (pcnt_reg >= PCNT_GUARD)) begin
            an_raw[idx_reg] = 1'b1;
        end
        seg_raw = en ? dec_segs : SEG_OFF;
        dp_raw  = en && act_dp_reg[idx_reg];
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an_pol
        assign an_next[gi] = apply_pol(an_raw[gi], ACTIVE_LOW);
    end
    for (genvar gi = 0; gi < 7; gi++) begin : g_seg_pol
        assign seg_next[gi] = apply_pol(seg_raw[gi], ACTIVE_LOW);
    end
    assign dp_next = apply_pol(dp_raw, ACTIVE_LOW);

    always_ff @(posedge clockin or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_reg        <= '0;
            idx_reg         <= '0;
            pend_digits_reg <= '0;
            pend_dp_reg     <= '0;
            act_digits_reg  <= '0;
            act_dp_reg      <= '0;
            an_reg          <= {DIGITS{PIN_OFF}};
            seg_reg         <= {7{PIN_OFF}};
            dp_reg          <= PIN_OFF;
            frame_tick_reg  <= 1'b0;
        end else begin
            if (en) begin
                if (advance) begin
                    pcnt_reg <= '0;
                    idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                end else begin
                    pcnt_reg <= pcnt_reg + 1'b1;
                end
            end

            if (load) begin
                pend_digits_reg <= digits_in;
                pend_dp_reg     <= dp_in;
            end

            // A load landing on the wrap edge bypasses pend so act never mixes loads.
            if (wrap) begin
                act_digits_reg <= load ? digits_in : pend_digits_reg;
                act_dp_reg     <= load ? dp_in     : pend_dp_reg;
            end

            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_tick_reg <= wrap;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: vector table with scoreboard plus
// hand-written sequences for wrap-edge loads, enable gaps and reset pulses.
module tb_seg_display_scanner;

    localparam int DIGITS  = 4;
    localparam int CLK_HZ  = 40;
    localparam int SCAN_HZ = 4;
    localparam int GUARD   = 2;

    logic        clockin   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        en        = 1'b0;
    logic        load      = 1'b0;
    logic        blank_lz  = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in     = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    seg_display_scanner #(
        .DIGITS     (DIGITS),
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .GUARD      (GUARD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clockin    (clockin),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clockin = ~clockin;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         digit;
    } sb_item_t;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dps;
        logic        blank;
        logic [27:0] segs;   // expected active-low glyphs {d3,d2,d1,d0}
        logic [3:0]  dpo;    // expected active-low dp {d3,d2,d1,d0}
    } vec_t;

    sb_item_t   sb_q[$];
    vec_t       vectors[7];
    logic [3:0] prev_an = 4'hF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: compares on the first lit cycle of each slot.
    always @(negedge clockin) begin
        sb_item_t e;
        if (sb_q.size() > 0 && an != 4'hF && an != prev_an) begin
            e = sb_q.pop_front();
            check($sformatf("sb_an_d%0d", e.digit), an, e.an);
            check($sformatf("sb_seg_d%0d", e.digit), seg, e.seg);
            check($sformatf("sb_dp_d%0d", e.digit), dp, e.dp);
        end
        prev_an <= an;
    end

    task automatic wait_tick(input string name);
        int k;
        k = 0;
        while (k < 100) begin
            @(negedge clockin);
            k++;
            if (frame_tick) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: frame_tick timeout got 0 expected 1", name);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 100) begin
            @(negedge clockin);
            k++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard left %0d entries expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Free-running scan expectation: output at step k reflects scan position start_p+k.
    task automatic run_scan(input int start_p, input int ncyc, input logic [27:0] segs,
                            input logic [3:0] dpo, input string name);
        for (int k = 0; k < ncyc; k++) begin
            int         p;
            int         ph;
            int         sl;
            logic [3:0] ea;
            @(negedge clockin);
            p  = start_p + k;
            ph = p % 10;
            sl = (p / 10) % 4;
            ea = (ph >= GUARD) ? ~(4'b0001 << sl) : 4'b1111;
            check($sformatf("%s_an_p%0d", name, p), an, ea);
            check($sformatf("%s_ft_p%0d", name, p), frame_tick, (p % 40) == 39);
            if (ph >= GUARD) begin
                check($sformatf("%s_seg_p%0d", name, p), seg, segs[7*sl +: 7]);
                check($sformatf("%s_dp_p%0d", name, p), dp, dpo[sl]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors[0] = '{16'h12AF, 4'b0010, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1101};
        vectors[1] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
        vectors[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vectors[3] = '{16'h0000, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vectors[4] = '{16'h8E5C, 4'b0101, 1'b1, {7'h00, 7'h06, 7'h12, 7'h46}, 4'b1010};
        vectors[5] = '{16'h0B07, 4'b0000, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}, 4'b1111};
        vectors[6] = '{16'h9D46, 4'b1111, 1'b0, {7'h10, 7'h21, 7'h19, 7'h02}, 4'b0000};

        // Reset values while held in reset.
        repeat (3) @(negedge clockin);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_ft", frame_tick, 1'b0);

        // Release with scanning enabled; act is zero so every digit shows 0.
        reset_n = 1'b1;
        en      = 1'b1;
        run_scan(0, 50, {4{7'h40}}, 4'hF, "post_reset");
        $display("txn: post-reset scan, 50 cycles");

        // Table vectors through the scoreboard.
        for (int v = 0; v < 7; v++) begin
            digits_in = vectors[v].digits;
            dp_in     = vectors[v].dps;
            blank_lz  = vectors[v].blank;
            load      = 1'b1;
            @(negedge clockin);
            load      = 1'b0;
            wait_tick($sformatf("vec%0d_tick", v));
            for (int d = 0; d < 4; d++) begin
                sb_item_t e;
                e.an    = ~(4'b0001 << d);
                e.seg   = vectors[v].segs[7*d +: 7];
                e.dp    = vectors[v].dpo[d];
                e.digit = d;
                sb_q.push_back(e);
            end
            drain($sformatf("vec%0d_drain", v));
            $display("txn: vector %0d digits=%h dp=%b blank=%0d", v,
                     vectors[v].digits, vectors[v].dps, vectors[v].blank);
        end

        // Load on the wrap edge itself is shown from the very next slot.
        wait_tick("wrapload_tick");
        repeat (39) @(negedge clockin);
        digits_in = 16'h0005;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        load      = 1'b1;
        @(negedge clockin);
        check("wrapload_ft", frame_tick, 1'b1);
        load = 1'b0;
        repeat (3) @(negedge clockin);
        check("wrapload_an", an, 4'b1110);
        check("wrapload_seg", seg, 7'h12);
        $display("txn: load on wrap edge");

        // Load one cycle after the wrap waits a whole frame.
        wait_tick("lateload_tick");
        digits_in = 16'h0007;
        load      = 1'b1;
        @(negedge clockin);
        load = 1'b0;
        repeat (2) @(negedge clockin);
        check("lateload_old_an", an, 4'b1110);
        check("lateload_old_seg", seg, 7'h12);
        repeat (40) @(negedge clockin);
        check("lateload_new_an", an, 4'b1110);
        check("lateload_new_seg", seg, 7'h78);
        $display("txn: load one cycle after wrap");

        // Enable dropped for 7 cycles mid-slot, then scanning resumes in place.
        wait_tick("en_tick");
        repeat (4) @(negedge clockin);
        check("en_pre_an", an, 4'b1110);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clockin);
            check($sformatf("en_off_an_%0d", k), an, 4'hF);
            check($sformatf("en_off_seg_%0d", k), seg, 7'h7F);
            check($sformatf("en_off_dp_%0d", k), dp, 1'b1);
            check($sformatf("en_off_ft_%0d", k), frame_tick, 1'b0);
        end
        en = 1'b1;
        run_scan(4, 30, {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF, "en_resume");
        $display("txn: enable gap of 7 cycles");

        // Reset pulse mid-frame discards both the pending load and act.
        wait_tick("rstpulse_tick");
        digits_in = 16'h12AF;
        dp_in     = 4'b0010;
        load      = 1'b1;
        @(negedge clockin);
        load = 1'b0;
        repeat (5) @(negedge clockin);
        reset_n = 1'b0;
        #1;
        check("rstpulse_an", an, 4'hF);
        check("rstpulse_seg", seg, 7'h7F);
        check("rstpulse_dp", dp, 1'b1);
        check("rstpulse_ft", frame_tick, 1'b0);
        @(negedge clockin);
        reset_n = 1'b1;
        run_scan(0, 90, {4{7'h40}}, 4'hF, "rstpulse_scan");
        $display("txn: reset pulse mid-frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
